// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared state encoding, reset PC and instruction field positions
package instruction_fetch_unit_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10
    } fetchState_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

    function automatic logic [31:0] branchOffset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction
endpackage

// File: rtl/instruction_fetch_unit_next_pc.sv
// NextPCLogic: combinational next-PC selection (jump, taken branch, or sequential)
module NextPCLogic
    import instruction_fetch_unit_pkg::*;
(
    input  logic [31:0] PC,
    input  logic [31:0] Instruction,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        ALUZero,
    output logic [31:0] NextPC
);
    logic [31:0] pcPlus4;
    logic        unusedOpcode;
    assign pcPlus4      = PC + 32'd4;
    assign unusedOpcode = ^Instruction[OPCODE_MSB:OPCODE_LSB];
    // Jump outranks a taken branch
    always_comb NextPC = Jump ? {pcPlus4[31:28], Instruction[TARGET_MSB:TARGET_LSB], 2'b00}
                       : (Branch && ALUZero) ? pcPlus4 + branchOffset(Instruction[IMM_MSB:IMM_LSB])
                       : pcPlus4;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: MIPS fetch stage owning PC, instruction register and the imem handshake
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
    input  logic        CLK,
    input  logic        Reset,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic [31:0] IMemData,
    output logic        InstrValid,
    input  logic        InstrAccept,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        ALUZero,
    output logic [31:0] Instruction,
    output logic [5:0]  Opcode,
    output logic [5:0]  Funct,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] InstrCount
);
    fetchState_t state;
    logic [31:0] nextPC;

    NextPCLogic nextPCLogic (
        .PC(PC),
        .Instruction(Instruction),
        .Branch(Branch),
        .Jump(Jump),
        .ALUZero(ALUZero),
        .NextPC(nextPC)
    );

    assign IMemAddr = PC;
    assign PCPlus4  = PC + 32'd4;
    assign Opcode   = Instruction[OPCODE_MSB:OPCODE_LSB];
    assign Funct    = Instruction[FUNCT_MSB:FUNCT_LSB];

    // Handshake outputs are registered alongside the state so no input reaches them combinationally
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= IDLE;
            IMemReq     <= 1'b0;
            InstrValid  <= 1'b0;
            PC          <= RESET_PC;
            Instruction <= '0;
            InstrCount  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= FETCH;
                    IMemReq <= 1'b1;
                end
                FETCH: if (IMemReady) begin
                    state       <= HOLD;
                    IMemReq     <= 1'b0;
                    InstrValid  <= 1'b1;
                    Instruction <= IMemData;
                end
                HOLD: if (InstrAccept) begin
                    state      <= FETCH;
                    IMemReq    <= 1'b1;
                    InstrValid <= 1'b0;
                    PC         <= nextPC;
                    InstrCount <= InstrCount + 32'd1;
                end
                default: begin
                    state      <= IDLE;
                    IMemReq    <= 1'b0;
                    InstrValid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench; stimulus queues expected fetches/holds, a monitor checks them
module tb_instruction_fetch_unit;
    logic        CLK = 0, Reset = 1, IMemReady = 0, InstrAccept = 0, Branch = 0, Jump = 0, ALUZero = 0;
    logic [31:0] IMemData = 0;
    logic        IMemReq, InstrValid;
    logic [31:0] IMemAddr, Instruction, PC, PCPlus4, InstrCount;
    logic [5:0]  Opcode, Funct;

    logic        rst2 = 1, ready2 = 0, accept2 = 0;
    logic        req2, valid2;
    logic [31:0] addr2, instr2, pc2, pcp42, cnt2;
    logic [5:0]  op2, fn2;

    int checks = 0, errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] count;
    } holdExp_t;

    logic [31:0] fetchQ[$];
    holdExp_t    holdQ[$];

    always #5 CLK = ~CLK;

    instruction_fetch_unit dut (
        .CLK(CLK), .Reset(Reset), .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady),
        .IMemData(IMemData), .InstrValid(InstrValid), .InstrAccept(InstrAccept), .Branch(Branch),
        .Jump(Jump), .ALUZero(ALUZero), .Instruction(Instruction), .Opcode(Opcode), .Funct(Funct),
        .PC(PC), .PCPlus4(PCPlus4), .InstrCount(InstrCount)
    );

    // Second instance starts near the top of the address space to exercise PC wrap
    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .CLK(CLK), .Reset(rst2), .IMemReq(req2), .IMemAddr(addr2), .IMemReady(ready2),
        .IMemData(32'h0000_0000), .InstrValid(valid2), .InstrAccept(accept2), .Branch(1'b0),
        .Jump(1'b0), .ALUZero(1'b0), .Instruction(instr2), .Opcode(op2), .Funct(fn2),
        .PC(pc2), .PCPlus4(pcp42), .InstrCount(cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    logic        prevReq = 0, prevValid = 0;
    logic [31:0] lastAddr = 0, heldInstr = 0, heldPC = 0;
    holdExp_t    h;

    always @(negedge CLK) begin
        if (IMemReq && !prevReq) begin
            if (fetchQ.size() == 0) miss("fetch_unexpected");
            else chk("fetch_addr", IMemAddr, fetchQ.pop_front());
            lastAddr = IMemAddr;
        end else if (IMemReq) chk("fetch_addr_stable", IMemAddr, lastAddr);
        if (InstrValid && !prevValid) begin
            if (holdQ.size() == 0) miss("hold_unexpected");
            else begin
                h = holdQ.pop_front();
                chk("hold_pc", PC, h.pc);
                chk("hold_pcplus4", PCPlus4, h.pc + 32'd4);
                chk("hold_instr", Instruction, h.instr);
                chk("hold_opcode", {26'd0, Opcode}, {26'd0, h.instr[31:26]});
                chk("hold_funct", {26'd0, Funct}, {26'd0, h.instr[5:0]});
                chk("hold_count", InstrCount, h.count);
            end
            heldInstr = Instruction;
            heldPC    = PC;
        end else if (InstrValid) begin
            chk("hold_stable_instr", Instruction, heldInstr);
            chk("hold_stable_pc", PC, heldPC);
        end
        if (IMemReq && InstrValid) miss("req_and_valid_together");
        prevReq   = IMemReq;
        prevValid = InstrValid;
    end

    task automatic waitFor(input string name, input bit forReq);
        int n = 0;
        while (!(forReq ? IMemReq : InstrValid)) begin
            @(negedge CLK);
            n++;
            if (n > 50) begin
                miss(name);
                return;
            end
        end
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] data, input int delay, input logic [31:0] count);
        holdQ.push_back('{pc, data, count});
        waitFor("wait_req", 1'b1);
        repeat (delay) begin
            IMemReady = 0; IMemData = ~data; InstrAccept = 1; Jump = 1;
            @(negedge CLK);
            chk("stall_req", {31'd0, IMemReq}, 32'd1);
            chk("stall_no_valid", {31'd0, InstrValid}, 32'd0);
        end
        InstrAccept = 0; Jump = 0; IMemReady = 1; IMemData = data;
        @(negedge CLK);
        IMemReady = 0; IMemData = 32'hDEAD_BEEF;
        chk("valid_next_cycle", {31'd0, InstrValid}, 32'd1);
    endtask

    task automatic retire(input bit b, input bit j, input bit z, input int stall, input logic [31:0] nextExp);
        waitFor("wait_valid", 1'b0);
        repeat (stall) @(negedge CLK);
        fetchQ.push_back(nextExp);
        InstrAccept = 1; Branch = b; Jump = j; ALUZero = z;
        @(negedge CLK);
        InstrAccept = 0; Branch = 0; Jump = 0; ALUZero = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        fetchQ.push_back(32'h0);
        repeat (3) @(negedge CLK);
        chk("rst_pc", PC, 32'h0);
        chk("rst_pcplus4", PCPlus4, 32'h4);
        chk("rst_addr", IMemAddr, 32'h0);
        chk("rst_valid", {31'd0, InstrValid}, 32'd0);
        chk("rst_req", {31'd0, IMemReq}, 32'd0);
        chk("rst_count", InstrCount, 32'h0);
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_wrap_pc", pc2, 32'hFFFF_FFFC);
        chk("rst_wrap_pcplus4", pcp42, 32'h0);
        Reset = 0;
        @(negedge CLK);
        chk("req_second_cycle", {31'd0, IMemReq}, 32'd1);

        issue(32'h0, 32'h8C01_0004, 0, 0);
        retire(0, 0, 0, 0, 32'h4);
        issue(32'h4, 32'h0800_0004, 3, 1);
        retire(0, 1, 0, 2, 32'h10);
        issue(32'h10, 32'h1000_FFFF, 0, 2);
        retire(1, 0, 1, 0, 32'h10);
        issue(32'h10, 32'h1000_FFFF, 0, 3);
        retire(1, 0, 0, 0, 32'h14);
        issue(32'h14, 32'h0800_0010, 1, 4);
        retire(0, 1, 0, 0, 32'h40);
        issue(32'h40, 32'h0800_0100, 0, 5);
        retire(0, 1, 0, 0, 32'h400);
        issue(32'h400, 32'h0800_0010, 0, 6);
        retire(0, 1, 0, 0, 32'h40);
        issue(32'h40, 32'h0800_0100, 0, 7);
        retire(1, 1, 1, 0, 32'h400);

        chk("pre_reset_in_fetch", {31'd0, IMemReq}, 32'd1);
        fetchQ.push_back(32'h0);
        Reset = 1;
        @(negedge CLK);
        Reset = 0; IMemReady = 1; IMemData = 32'hDEAD_BEEF;
        chk("midrst_req", {31'd0, IMemReq}, 32'd0);
        chk("midrst_valid", {31'd0, InstrValid}, 32'd0);
        chk("midrst_instr", Instruction, 32'h0);
        chk("midrst_count", InstrCount, 32'h0);
        chk("midrst_pc", PC, 32'h0);
        @(negedge CLK);
        IMemReady = 0;
        chk("late_ready_req", {31'd0, IMemReq}, 32'd1);
        chk("late_ready_instr", Instruction, 32'h0);
        @(negedge CLK);
        chk("late_ready_no_valid", {31'd0, InstrValid}, 32'd0);

        rst2 = 0;
        for (int n = 0; !req2; n++) begin
            @(negedge CLK);
            if (n > 20) begin miss("wrap_wait_req"); break; end
        end
        chk("wrap_fetch_addr", addr2, 32'hFFFF_FFFC);
        ready2 = 1;
        @(negedge CLK);
        ready2 = 0;
        chk("wrap_valid", {31'd0, valid2}, 32'd1);
        accept2 = 1;
        @(negedge CLK);
        accept2 = 0;
        chk("wrap_req", {31'd0, req2}, 32'd1);
        chk("wrap_next_addr", addr2, 32'h0);
        chk("wrap_pcplus4", pcp42, 32'h4);
        chk("wrap_count", cnt2, 32'h1);

        chk("fetchq_drained", fetchQ.size(), 32'd0);
        chk("holdq_drained", holdQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
